// File: rtl/load_control_unit.sv
// Load sequencer: one memory read, MDR capture, size extract and extend.
// Define LOAD_SIGN_EXT_EN to honour load_signed on halfword/byte loads.
module load_control_unit #(
    parameter int MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  load_sel,
    input  logic        load_signed,
    input  logic [31:0] addr,
    input  logic [31:0] mem_data,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_out
);

`ifdef LOAD_SIGN_EXT_EN
    localparam logic SEXT_EN = 1'b1;
`else
    localparam logic SEXT_EN = 1'b0;
`endif

    localparam logic [3:0] LAST = 4'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        CAPTURE,
        DONE
    } state_t;

    state_t      state;
    logic [31:0] mdr;
    logic [1:0]  sel_q;
    logic        sign_q;
    logic [1:0]  out_sel;
    logic        out_sign;
    logic [3:0]  cnt;

    // Size/sign for the result are copied at capture so a new
    // request cannot disturb load_out before its own done.
    always_comb begin
        load_out = mdr;
        unique case (out_sel)
            2'b01:   load_out = {{16{out_sign & mdr[15]}}, mdr[15:0]};
            2'b10:   load_out = {{24{out_sign & mdr[7]}}, mdr[7:0]};
            default: load_out = mdr;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            mdr      <= '0;
            sel_q    <= '0;
            sign_q   <= 1'b0;
            out_sel  <= '0;
            out_sign <= 1'b0;
            cnt      <= '0;
            mem_addr <= '0;
            mem_rd   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        mem_addr <= addr;
                        sel_q    <= load_sel;
                        sign_q   <= load_signed;
                        cnt      <= '0;
                        mem_rd   <= 1'b1;
                        busy     <= 1'b1;
                        state    <= READ;
                    end
                end
                READ: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == LAST) begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    mdr      <= mem_data;
                    out_sel  <= sel_q;
                    out_sign <= sign_q & SEXT_EN;
                    done     <= 1'b1;
                    mem_rd   <= 1'b0;
                    mem_addr <= '0;
                    state    <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_control_unit.sv
// Scoreboard bench for load_control_unit, latency 1 and latency 3.
// Expected results are queued at start and checked on done.
module tb_load_control_unit;

`ifdef LOAD_SIGN_EXT_EN
    localparam logic SEXT = 1'b1;
`else
    localparam logic SEXT = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        start1;
    logic        start3;
    logic [1:0]  load_sel;
    logic        load_signed;
    logic [31:0] addr;
    logic [31:0] mem_data;

    logic [31:0] maddr1, maddr3, out1, out3;
    logic        rd1, rd3, busy1, busy3, done1, done3;

    logic        use3;
    logic [31:0] o_addr, o_out;
    logic        o_rd, o_busy, o_done;

    int checks = 0;
    int failures = 0;
    logic [31:0] sbq[$];

    load_control_unit #(.MEM_LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1),
        .load_sel(load_sel), .load_signed(load_signed),
        .addr(addr), .mem_data(mem_data),
        .mem_addr(maddr1), .mem_rd(rd1), .busy(busy1),
        .done(done1), .load_out(out1)
    );

    load_control_unit #(.MEM_LATENCY(3)) dut3 (
        .clk(clk), .reset(reset), .start(start3),
        .load_sel(load_sel), .load_signed(load_signed),
        .addr(addr), .mem_data(mem_data),
        .mem_addr(maddr3), .mem_rd(rd3), .busy(busy3),
        .done(done3), .load_out(out3)
    );

    assign o_addr = use3 ? maddr3 : maddr1;
    assign o_out  = use3 ? out3 : out1;
    assign o_rd   = use3 ? rd3 : rd1;
    assign o_busy = use3 ? busy3 : busy1;
    assign o_done = use3 ? done3 : done1;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] d,
                                          input logic [1:0] s,
                                          input logic g);
        logic sx;
        sx = g & SEXT;
        case (s)
            2'b01: return sx && d[15] ? {16'hffff, d[15:0]}
                                      : {16'h0000, d[15:0]};
            2'b10: return sx && d[7] ? {24'hffffff, d[7:0]}
                                     : {24'h000000, d[7:0]};
            default: return d;
        endcase
    endfunction

    always @(negedge clk) begin
        if (o_done) begin
            if (sbq.size() == 0) chk("extra_done", 1, 0);
            else chk("load_out", o_out, sbq.pop_front());
        end
    end

    // mode: 0 plain, 1 second start right after acceptance,
    // 2 start held during the done cycle
    task automatic run_op(input bit d3, input logic [31:0] a,
                          input logic [1:0] sel, input logic sg,
                          input logic [31:0] md,
                          input logic [31:0] md_late,
                          input logic [31:0] exp, input int mode);
        int lat;
        int rdn;
        int k;
        bit seen;
        lat = d3 ? 3 : 1;
        use3 = d3;
        @(negedge clk);
        addr = a;
        load_sel = sel;
        load_signed = sg;
        mem_data = md;
        if (d3) start3 = 1'b1;
        else start1 = 1'b1;
        sbq.push_back(exp);
        rdn = 0;
        seen = 0;
        k = 0;
        while (!seen && k < 40) begin
            @(negedge clk);
            k++;
            start1 = 1'b0;
            start3 = 1'b0;
            if (k == 1) begin
                addr = ~a;
                load_sel = ~sel;
                load_signed = ~sg;
                if (mode == 1) begin
                    addr = 32'h80;
                    if (d3) start3 = 1'b1;
                    else start1 = 1'b1;
                end
            end
            if (k == 2) mem_data = md_late;
            if (o_rd) begin
                rdn++;
                chk("rd_addr", o_addr, a);
            end
            if (o_done) seen = 1;
        end
        chk("done_seen", 32'(seen), 1);
        chk("latency", k, lat + 2);
        chk("rd_cycles", rdn, lat + 1);
        chk("done_addr", o_addr, 0);
        mem_data = ~md_late;
        if (mode == 2) begin
            if (d3) start3 = 1'b1;
            else start1 = 1'b1;
        end
        @(negedge clk);
        start1 = 1'b0;
        start3 = 1'b0;
        chk("idle_busy", 32'(o_busy), 0);
        chk("hold_out", o_out, exp);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] md;
        logic [31:0] ml;
        logic [1:0]  s;
        logic        g;
        clk = 1'b0;
        reset = 1'b1;
        start1 = 1'b0;
        start3 = 1'b0;
        load_sel = 2'b00;
        load_signed = 1'b0;
        addr = '0;
        mem_data = '0;
        use3 = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_addr", maddr1, 0);
        chk("rst_rd", 32'(rd1), 0);
        chk("rst_busy", 32'(busy1), 0);
        chk("rst_done", 32'(done1), 0);
        chk("rst_out", out1, 0);
        reset = 1'b0;

        run_op(0, 32'h40, 2'b00, 0, 32'hdeadbeef, 32'hdeadbeef,
               32'hdeadbeef, 0);
        run_op(0, 32'h44, 2'b01, 0, 32'h1234f00d, 32'h1234f00d,
               32'h0000f00d, 0);
        run_op(0, 32'h46, 2'b01, 1, 32'h1234f00d, 32'h1234f00d,
               SEXT ? 32'hfffff00d : 32'h0000f00d, 2);
        run_op(0, 32'h48, 2'b10, 0, 32'haabbcc85, 32'haabbcc85,
               32'h00000085, 0);
        run_op(0, 32'h49, 2'b10, 1, 32'haabbcc85, 32'haabbcc85,
               SEXT ? 32'hffffff85 : 32'h00000085, 0);
        run_op(0, 32'h4c, 2'b11, 1, 32'h8badf00d, 32'h8badf00d,
               32'h8badf00d, 0);
        run_op(0, 32'h40, 2'b00, 0, 32'h0badcafe, 32'h0badcafe,
               32'h0badcafe, 1);
        repeat (4) @(negedge clk);

        // abandon a load in CAPTURE
        use3 = 1'b0;
        addr = 32'h100;
        load_sel = 2'b00;
        mem_data = 32'h55;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        @(negedge clk);
        chk("mid_busy", 32'(busy1), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_busy", 32'(busy1), 0);
        chk("mid_rst_rd", 32'(rd1), 0);
        chk("mid_rst_out", out1, 0);
        chk("mid_rst_done", 32'(done1), 0);
        repeat (4) @(negedge clk);

        reset = 1'b1;
        start1 = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start1 = 1'b0;
        chk("rst_start_busy", 32'(busy1), 0);
        @(negedge clk);
        chk("rst_start_idle", 32'(busy1), 0);

        run_op(1, 32'h200, 2'b00, 0, 32'h11111111, 32'h22222222,
               32'h22222222, 0);
        run_op(1, 32'h204, 2'b10, 1, 32'h000000ff, 32'h000000f0,
               SEXT ? 32'hfffffff0 : 32'h000000f0, 0);

        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            md = $urandom;
            ml = $urandom;
            s = 2'($urandom_range(0, 3));
            g = 1'($urandom_range(0, 1));
            run_op(i[0], a, s, g, md, ml, model(ml, s, g), 0);
        end
        repeat (3) @(negedge clk);
        chk("sb_empty", sbq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_control_unit.md
Name: load_control_unit

Overview:
- Read-side counterpart of the datapath's store merge logic.
- Sequences one memory read for LW/LH/LB: latches address and size, holds the memory address for the memory's fixed latency, then captures the returned word into an internal MDR.
- Extracts the word, low halfword or low byte and extends it to 32 bits for register write-back.
- Sits between the multicycle control FSM and the memory / register-file write port.

Parameters:
- MEM_LATENCY, 1, cycles from address presented to mem_data valid; legal range 1..15.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; returns the block to IDLE
- start  input  1  request a load; accepted only in IDLE
- load_sel  input  2  size: 00 word, 01 halfword, 10 byte, 11 treated as word
- load_signed  input  1  extension select; honoured only with LOAD_SIGN_EXT_EN
- addr  input  32  byte address of the load
- mem_data  input  32  memory read data
- mem_addr  output  32  address presented to memory
- mem_rd  output  1  memory read enable; memory write enable is never driven by this block
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse: load_out updated
- load_out  output  32  extended load result; held until the next done

Behaviour:
- Reset values: mem_addr=0, mem_rd=0, busy=0, done=0, load_out=0. Internal MDR, latched size/sign and counter all cleared. State goes to IDLE.
- States: IDLE, READ, CAPTURE, DONE.
- IDLE:
  - When start=1, latch addr, load_sel and load_signed, clear the counter, and go to READ.
  - start is ignored in all other states. There is no queueing.
- READ:
  - mem_addr = latched address, mem_rd=1.
  - The counter increments each cycle. After MEM_LATENCY cycles in READ, go to CAPTURE.
- CAPTURE:
  - mem_addr is still held and mem_rd=1.
  - mem_data is registered into the MDR at the end of the cycle. Go to DONE.
- DONE:
  - done=1 for exactly one cycle, and load_out takes the extracted value on entry to DONE.
  - mem_rd=0, mem_addr returns to 0. Go to IDLE.
- Latency: start sampled at edge N gives done=1 in cycle N+MEM_LATENCY+2. For MEM_LATENCY=1, the pulse comes 3 cycles after the start edge.
- Back-to-back operation: start may be asserted in the cycle done=1. It is sampled on the edge that moves the block to IDLE, so it is not accepted; the next start is accepted in the IDLE cycle.
- Extraction, always from the low bits of the word (matching the store merge):
  - word: mem_data[31:0]
  - halfword: mem_data[15:0]
  - byte: mem_data[7:0]
- Address bits [1:0] are passed through unchanged. No alignment check and no lane shifting.
- Extension: zero-extension unless the optional feature is enabled and the latched load_signed=1.
- Input changes after acceptance (addr, load_sel, load_signed) have no effect on the operation in flight.
- Reset asserted in any state:
  - Next cycle is IDLE with all outputs at reset values.
  - An in-flight load is abandoned, done is not pulsed and load_out is cleared.
- Reset and start both high: reset wins, no operation is started.

Optional Feature:
- Macro: LOAD_SIGN_EXT_EN
- Defined:
  - load_signed=1 sign-extends a halfword from bit 15 and a byte from bit 7.
  - load_signed=0 zero-extends.
  - Word loads are unaffected.
- Undefined: load_signed is ignored and all sub-word loads zero-extend.

Test Plan:
- Reset check: hold reset 2 cycles, then start=1, addr=0x40, load_sel=00, mem_data=0xDEADBEEF. Expect mem_rd=1 with mem_addr=0x40 for 2 cycles, done pulse 3 cycles after the start edge, load_out=0xDEADBEEF, busy low afterwards.
- Halfword load: load_sel=01, mem_data=0x1234F00D. Expect load_out=0x0000F00D. With LOAD_SIGN_EXT_EN and load_signed=1, expect 0xFFFFF00D.
- Byte load: load_sel=10, mem_data=0xAABBCC85. Expect load_out=0x00000085. With LOAD_SIGN_EXT_EN and load_signed=1, expect 0xFFFFFF85. Without the macro, load_signed=1 still gives 0x00000085.
- Ignored start: pulse start again in the cycle after acceptance, with addr=0x80. Expect exactly one done, mem_addr stays 0x40, and done occurs 3 cycles after the first start.
- Reset mid-load: assert reset during CAPTURE. Expect the next cycle IDLE, busy=0, mem_rd=0, load_out=0, and no done pulse.
- Slow memory: MEM_LATENCY=3, word load. Expect mem_rd high for 4 cycles and done 5 cycles after the start edge. Changing mem_data before the capture edge must be reflected in the result; changing it after must not.
